// File: rtl/acc_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Define ACC_CTRL_BRANCH_EN to implement JMP (0xD) and JZ (0xE); otherwise they decode as NOP.
module acc_ctrl #(
  parameter int unsigned PC_W = 4
) (
  input  logic            clk,
  input  logic            CLB,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  input  logic            acc_zero,
  output logic [1:0]      SelAcc,
  output logic            loadAcc,
  output logic [2:0]      alu_op,
  output logic [3:0]      rf_addr,
  output logic            rf_we,
  output logic [3:0]      imm,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StHalt
  } state_e;

  localparam logic [3:0] OpLdi = 4'h1;
  localparam logic [3:0] OpLdr = 4'h2;
  localparam logic [3:0] OpStr = 4'h3;
  localparam logic [3:0] OpAdd = 4'h4;
  localparam logic [3:0] OpSub = 4'h5;
  localparam logic [3:0] OpAnd = 4'h6;
  localparam logic [3:0] OpOr  = 4'h7;
  localparam logic [3:0] OpXor = 4'h8;
  localparam logic [3:0] OpJmp = 4'hD;
  localparam logic [3:0] OpJz  = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [3:0]        arg_q, arg_d;
  logic [3:0]        op;

  assign op = ir_q[7:4];

  always_ff @(posedge clk or posedge CLB) begin
    if (CLB) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      arg_q   <= arg_d;
    end
  end

`ifndef ACC_CTRL_BRANCH_EN
  logic unused_acc_zero;
  assign unused_acc_zero = acc_zero;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    arg_d   = arg_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        arg_d   = ir_q[3:0];
        state_d = StExec;
      end
      StExec: begin
`ifdef ACC_CTRL_BRANCH_EN
        // acc_zero is sampled here so a preceding LDI is already visible.
        if ((op == OpJmp) || ((op == OpJz) && acc_zero)) begin
          pc_d = PC_W'(arg_q);
        end
`endif
        state_d = (op == OpHlt) ? StHalt : StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes decode purely from registered state so reset removes them at once.
  always_comb begin
    SelAcc  = 2'b00;
    loadAcc = 1'b0;
    alu_op  = 3'd0;
    rf_we   = 1'b0;
    if (state_q == StExec) begin
      case (op)
        OpLdi: begin
          SelAcc  = 2'b10;
          loadAcc = 1'b1;
        end
        OpLdr: begin
          SelAcc  = 2'b01;
          loadAcc = 1'b1;
        end
        OpStr: rf_we = 1'b1;
        OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
          alu_op  = 3'(op - OpAdd);
          loadAcc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = (state_q == StFetch);
  assign rf_addr   = arg_q;
  assign imm       = arg_q;
  assign busy      = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec);
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl: instruction-level reference model plus directed programs.
module tb_acc_ctrl;
  localparam int PC_W = 4;
  localparam int MIdle = 0, MFetch = 1, MDec = 2, MExec = 3, MHalt = 4;

  logic            clk = 1'b0;
  logic            CLB;
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack;
  logic [7:0]      imem_data;
  logic            acc_zero;
  logic [1:0]      SelAcc;
  logic            loadAcc;
  logic [2:0]      alu_op;
  logic [3:0]      rf_addr;
  logic            rf_we;
  logic [3:0]      imm;
  logic            busy;
  logic            halted;

  logic [7:0] mem [16];
  assign imem_data = mem[imem_addr];

  acc_ctrl #(.PC_W(PC_W)) dut (
    .clk(clk), .CLB(CLB), .start(start), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .acc_zero(acc_zero), .SelAcc(SelAcc),
    .loadAcc(loadAcc), .alu_op(alu_op), .rf_addr(rf_addr), .rf_we(rf_we), .imm(imm),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-opcode effect tables, filled from the instruction set description.
  logic [1:0] t_sel  [16];
  logic       t_load [16];
  logic       t_we   [16];
  logic [2:0] t_alu  [16];

  // Reference model: instruction phases and architectural PC/IR/arg.
  int              m_mode;
  logic [PC_W-1:0] m_pc;
  logic [7:0]      m_ir;
  logic [3:0]      m_arg;

  always @(posedge clk or posedge CLB) begin
    if (CLB) begin
      m_mode <= MIdle;
      m_pc   <= '0;
      m_ir   <= '0;
      m_arg  <= '0;
    end else begin
      case (m_mode)
        MIdle, MHalt: if (start) begin
          m_mode <= MFetch;
          m_pc   <= '0;
        end
        MFetch: if (imem_ack) begin
          m_ir   <= mem[m_pc];
          m_pc   <= PC_W'((int'(m_pc) + 1) % (1 << PC_W));
          m_mode <= MDec;
        end
        MDec: begin
          m_arg  <= m_ir[3:0];
          m_mode <= MExec;
        end
        MExec: begin
`ifdef ACC_CTRL_BRANCH_EN
          if (m_ir[7:4] == 4'hD || (m_ir[7:4] == 4'hE && acc_zero)) m_pc <= PC_W'(m_arg);
`endif
          m_mode <= (m_ir[7:4] == 4'hF) ? MHalt : MFetch;
        end
        default: m_mode <= MIdle;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en && !CLB) begin
      chk("cmp_addr", 32'(imem_addr), 32'(m_pc));
      chk("cmp_req", 32'(imem_req), 32'(m_mode == MFetch));
      chk("cmp_busy", 32'(busy), 32'(m_mode == MFetch || m_mode == MDec || m_mode == MExec));
      chk("cmp_halted", 32'(halted), 32'(m_mode == MHalt));
      chk("cmp_rf_addr", 32'(rf_addr), 32'(m_arg));
      chk("cmp_imm", 32'(imm), 32'(m_arg));
      chk("cmp_selacc", 32'(SelAcc), (m_mode == MExec) ? 32'(t_sel[m_ir[7:4]]) : 32'd0);
      chk("cmp_loadacc", 32'(loadAcc), (m_mode == MExec) ? 32'(t_load[m_ir[7:4]]) : 32'd0);
      chk("cmp_rf_we", 32'(rf_we), (m_mode == MExec) ? 32'(t_we[m_ir[7:4]]) : 32'd0);
      chk("cmp_alu_op", 32'(alu_op), (m_mode == MExec) ? 32'(t_alu[m_ir[7:4]]) : 32'd0);
      chk("cmp_strobe_excl", 32'(loadAcc & rf_we), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    CLB = 1'b1;
    #1;
    CLB = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  int reqcnt;

  initial begin
    for (int i = 0; i < 16; i++) begin
      t_sel[i]  = (i == 1) ? 2'b10 : (i == 2) ? 2'b01 : 2'b00;
      t_load[i] = (i == 1) || (i == 2) || (i >= 4 && i <= 8);
      t_we[i]   = (i == 3);
      t_alu[i]  = (i >= 4 && i <= 8) ? 3'(i - 4) : 3'd0;
    end
    clear_mem();
    CLB = 1'b1; start = 1'b0; imem_ack = 1'b0; acc_zero = 1'b0;
    tick(); tick();
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_strobes", {27'd0, loadAcc, rf_we, SelAcc, imem_req}, 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    CLB = 1'b0;
    chk_en = 1'b1;

    // LDI 5; STR 2; HLT with immediate ack.
    mem[0] = 8'h15; mem[1] = 8'h32; mem[2] = 8'hF0; imem_ack = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("prog_c1_req", 32'(imem_req), 1);
    tick(); tick();
    chk("prog_c3_load", 32'(loadAcc), 1);
    chk("prog_c3_sel", 32'(SelAcc), 2);
    chk("prog_c3_imm", 32'(imm), 5);
    tick(); tick(); tick();
    chk("prog_c6_we", 32'(rf_we), 1);
    chk("prog_c6_addr", 32'(rf_addr), 2);
    chk("prog_c6_load", 32'(loadAcc), 0);
    tick(); tick(); tick();
    chk("prog_c9_halted", 32'(halted), 0);
    tick();
    chk("prog_halted", 32'(halted), 1);
    chk("prog_busy", 32'(busy), 0);

    // ADD 3 with ack delayed two cycles.
    do_reset(); clear_mem();
    mem[0] = 8'h43; imem_ack = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    reqcnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) imem_ack = 1'b1;
      if (imem_req) reqcnt++;
      tick();
    end
    imem_ack = 1'b0;
    chk("add_req_cycles", 32'(reqcnt), 3);
    chk("add_req_drop", 32'(imem_req), 0);
    tick();
    chk("add_alu_op", 32'(alu_op), 0);
    chk("add_sel", 32'(SelAcc), 0);
    chk("add_load", 32'(loadAcc), 1);
    chk("add_rf_addr", 32'(rf_addr), 3);

    // 16 NOPs: PC wraps 15 -> 0.
    do_reset(); clear_mem(); imem_ack = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("wrap_addr", 32'(imem_addr), 32'(i));
      tick(); tick(); tick();
    end
    chk("wrap_to_zero", 32'(imem_addr), 0);
    chk("wrap_req", 32'(imem_req), 1);

    // Branch opcodes: JZ 9 with acc_zero high and low, JMP 9.
    for (int k = 0; k < 3; k++) begin
      do_reset(); clear_mem();
      mem[0] = (k == 2) ? 8'hD9 : 8'hE9;
      acc_zero = (k == 0);
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      chk("br_no_strobes", {29'd0, loadAcc, rf_we, |SelAcc}, 0);
      tick();
`ifdef ACC_CTRL_BRANCH_EN
      chk("br_next_addr", 32'(imem_addr), (k == 1) ? 32'd1 : 32'd9);
`else
      chk("br_next_addr", 32'(imem_addr), 1);
`endif
    end
    acc_zero = 1'b0;

    // start during EXEC is ignored.
    do_reset(); clear_mem(); mem[0] = 8'h15;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy_addr", 32'(imem_addr), 1);
    chk("start_busy_req", 32'(imem_req), 1);

    // CLB mid-fetch and mid-exec.
    do_reset(); clear_mem(); mem[1] = 8'h15;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    imem_ack = 1'b0; tick();
    chk("clb_pre_addr", 32'(imem_addr), 1);
    CLB = 1'b1; #1;
    chk("clb_fetch_addr", 32'(imem_addr), 0);
    chk("clb_fetch_busy", 32'(busy), 0);
    chk("clb_fetch_req", 32'(imem_req), 0);
    CLB = 1'b0;
    mem[0] = 8'h15; imem_ack = 1'b1;
    tick();
    chk("clb_idle_busy", 32'(busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("clb_refetch_addr", 32'(imem_addr), 0);
    chk("clb_refetch_req", 32'(imem_req), 1);
    tick(); tick();
    chk("clb_exec_load", 32'(loadAcc), 1);
    CLB = 1'b1; #1;
    chk("clb_exec_load_drop", 32'(loadAcc), 0);
    chk("clb_exec_busy", 32'(busy), 0);
    CLB = 1'b0;

    // Randomized run against the model.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 4000; n++) begin
      tick();
      imem_ack = 1'($urandom_range(0, 1));
      acc_zero = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 11) == 0);
      if (n % 150 == 0) mem[$urandom_range(0, 15)] = 8'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
    end
    start = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
